vga_pixel_prefetch: RTL

- Upstream feeder for the VGA timing/output stage: prefetches pixels from the frame buffer's burst-read port into an on-chip FIFO.
- Presents them show-ahead on pixel_data, so a word is valid in the same cycle data_req (=de) is high.
- Restarts fetching at frame base on every vsync leading edge, so each frame starts aligned to pixel (0,0).

---
 rtl/vga_pkg.sv | 18 +
 rtl/sync_fifo_fwft.sv | 53 +++++
 rtl/vga_pixel_prefetch.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: prefetch FSM states, RGB565 black and 640x480 frame geometry.
package vga_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        REQ,
        BURST,
        DONE
    } fetch_state_t;

    localparam logic [15:0] RGB565_BLACK = 16'h0000;

    localparam int unsigned H_ACTIVE         = 640;
    localparam int unsigned V_ACTIVE         = 480;
    localparam int unsigned FRAME_PIXELS_VGA = H_ACTIVE * V_ACTIVE;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Show-ahead synchronous FIFO: the head word is visible on dout with no pop latency.
module sync_fifo_fwft #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned AW     = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [AW:0]       level,
    output logic              full,
    output logic              empty
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty && !clear;
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (clear)
                rd_ptr <= wr_ptr;
            else if (do_pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/vga_pixel_prefetch.sv
// Frame-buffer pixel prefetcher: burst-reads one frame into a show-ahead FIFO,
// restarting at the frame base on every vsync leading edge.
module vga_pixel_prefetch
    import vga_pkg::*;
#(
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned ADDR_W        = 24,
    parameter int unsigned DEPTH         = 512,
    parameter int unsigned AW            = 9,
    parameter int unsigned BURST_LEN     = 64,
    parameter int unsigned FRAME_PIXELS  = FRAME_PIXELS_VGA,
    parameter int unsigned BASE_ADDR     = 0,
    parameter int unsigned VS_ACTIVE_LOW = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vsync,
    input  logic              data_req,
    output logic [DATA_W-1:0] pixel_data,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic [7:0]        mem_rd_len,
    input  logic              mem_rd_ack,
    input  logic              mem_rd_valid,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [AW:0]       fifo_level,
    output logic              underflow,
    output logic              overflow
);

    localparam int unsigned RW = $clog2(FRAME_PIXELS + 1);
    localparam int unsigned OW = $clog2(BURST_LEN + 1);

    fetch_state_t      state, state_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic [RW-1:0]     remaining, remaining_n;
    logic [OW-1:0]     outstanding, outstanding_n;
    logic              discard, discard_n;
    logic              req_n;
    logic [7:0]        len_n;
    logic              underflow_n, overflow_n;
    logic              vs_q;
    logic              frame_start;
    logic              fifo_clear, fifo_push, fifo_full, fifo_empty;
    logic [7:0]        burst_len;
    logic [AW+1:0]     reserved;
    logic              space_ok;

    assign frame_start = (VS_ACTIVE_LOW != 0) ? (vs_q & ~vsync) : (~vs_q & vsync);
    assign fifo_push   = mem_rd_valid & ~discard;
    assign mem_rd_addr = addr;

    assign burst_len = (remaining >= RW'(BURST_LEN)) ? 8'(BURST_LEN) : 8'(remaining);
    assign reserved  = (AW+2)'(fifo_level) + (AW+2)'(outstanding);
    assign space_ok  = reserved <= (AW+2)'(DEPTH - BURST_LEN);

    sync_fifo_fwft #(
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (fifo_clear),
        .push  (fifo_push),
        .pop   (data_req),
        .din   (mem_rd_data),
        .dout  (pixel_data),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_n       = state;
        addr_n        = addr;
        remaining_n   = remaining;
        outstanding_n = outstanding;
        discard_n     = discard;
        req_n         = mem_rd_req;
        len_n         = mem_rd_len;
        fifo_clear    = 1'b0;
        underflow_n   = underflow | (data_req & fifo_empty);
        overflow_n    = overflow | (fifo_push & fifo_full);

        // Beats are counted in any state so a burst accepted on a frame edge can drain after FLUSH.
        if (mem_rd_valid && outstanding != '0) begin
            outstanding_n = outstanding - OW'(1);
            if (outstanding == OW'(1))
                discard_n = 1'b0;
        end

        unique case (state)
            IDLE, DONE: begin
                if (frame_start)
                    state_n = FLUSH;
            end
            FLUSH: begin
                fifo_clear  = 1'b1;
                addr_n      = ADDR_W'(BASE_ADDR);
                remaining_n = RW'(FRAME_PIXELS);
                underflow_n = 1'b0;
                state_n     = REQ;
            end
            REQ: begin
                if (mem_rd_req) begin
                    if (mem_rd_ack) begin
                        req_n         = 1'b0;
                        outstanding_n = OW'(mem_rd_len);
                        addr_n        = addr + ADDR_W'(mem_rd_len);
                        remaining_n   = remaining - RW'(mem_rd_len);
                        if (frame_start) begin
                            discard_n = 1'b1;
                            state_n   = FLUSH;
                        end else begin
                            state_n = BURST;
                        end
                    end else if (frame_start) begin
                        req_n   = 1'b0;
                        state_n = FLUSH;
                    end
                end else if (frame_start) begin
                    state_n = FLUSH;
                end else if (remaining == '0) begin
                    state_n = DONE;
                end else if (outstanding == '0 && space_ok) begin
                    req_n = 1'b1;
                    len_n = burst_len;
                end
            end
            BURST: begin
                if (outstanding_n == '0)
                    state_n = (discard || frame_start) ? FLUSH : REQ;
                else if (frame_start)
                    discard_n = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            addr        <= ADDR_W'(BASE_ADDR);
            remaining   <= '0;
            outstanding <= '0;
            discard     <= 1'b0;
            mem_rd_req  <= 1'b0;
            mem_rd_len  <= '0;
            underflow   <= 1'b0;
            overflow    <= 1'b0;
            vs_q        <= (VS_ACTIVE_LOW == 0);
        end else begin
            state       <= state_n;
            addr        <= addr_n;
            remaining   <= remaining_n;
            outstanding <= outstanding_n;
            discard     <= discard_n;
            mem_rd_req  <= req_n;
            mem_rd_len  <= len_n;
            underflow   <= underflow_n;
            overflow    <= overflow_n;
            vs_q        <= vsync;
        end
    end

endmodule
